regfile_mp: RTL and testbench

Parametrised multi-port register file for the pipelined core, replacing the single-write, two-read register file. It adds a configurable number of read ports and a second write port (load return), with same-cycle write-to-read bypass. It also carries a per-register pending scoreboard and a hardware scrub engine that zeroes the array after reset or on request. It sits between decode (reads, issue) and writeback (ALU port A, load port B).

---
 rtl/regfile_mp.sv | 140 ++++++++++++++
 tb/tb_regfile_mp.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two write ports, same-cycle
// write-to-read bypass, a per-register pending scoreboard and a scrub
// engine that zeroes the whole array after reset or on request.
module regfile_mp #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int NRD = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              busy,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*DW-1:0] rd,
  output logic [NRD-1:0]    rpend,
  input  logic              we_a,
  input  logic [AW-1:0]     wa_a,
  input  logic [DW-1:0]     wd_a,
  input  logic              we_b,
  input  logic [AW-1:0]     wa_b,
  input  logic [DW-1:0]     wd_b,
  input  logic              iss_v,
  input  logic [AW-1:0]     iss_a
);

  localparam int NREG = 1 << AW;

  typedef enum logic {
    SCRUB = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t          state;
  logic [AW-1:0]   scnt;
  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_nxt;
  logic [DW-1:0]   rf [NREG];

  logic idle;
  logic vwa;
  logic vwb;
  logic upd;

  // A write is architecturally valid in IDLE to any register but 0; it is
  // only committed when no scrub request arrives in the same cycle.
  assign idle = (state == IDLE);
  assign vwa  = idle && we_a && (wa_a != '0);
  assign vwb  = idle && we_b && (wa_b != '0);
  assign upd  = idle && !clr;
  assign busy = (state == SCRUB);

  // Scrub sequencer: walk scnt across the array once, then sit in IDLE until clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SCRUB;
      scnt  <= '0;
    end else begin
      case (state)
        SCRUB: begin
          if (scnt == '1) begin
            state <= IDLE;
          end
          scnt <= scnt + AW'(1);
        end
        IDLE: begin
          if (clr) begin
            state <= SCRUB;
            scnt  <= '0;
          end
        end
        default: begin
          state <= SCRUB;
          scnt  <= '0;
        end
      endcase
    end
  end

  // Next scoreboard value: writes retire a register, an issue marks it, issue wins.
  always_comb begin
    pend_nxt = pend;
    if (vwa) begin
      pend_nxt[wa_a] = 1'b0;
    end
    if (vwb) begin
      pend_nxt[wa_b] = 1'b0;
    end
    if (iss_v && (iss_a != '0)) begin
      pend_nxt[iss_a] = 1'b1;
    end
  end

  // Scoreboard register: cleared on reset and on a scrub request, frozen while scrubbing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else if (idle) begin
      if (clr) begin
        pend <= '0;
      end else begin
        pend <= pend_nxt;
      end
    end
  end

  // Storage array (no reset): the scrub zeroes it, otherwise port A then port B so B wins.
  always_ff @(posedge clk) begin
    if (state == SCRUB) begin
      rf[scnt] <= '0;
    end else if (upd) begin
      if (vwa) begin
        rf[wa_a] <= wd_a;
      end
      if (vwb) begin
        rf[wa_b] <= wd_b;
      end
    end
  end

  // Read ports: register 0 is hardwired zero, port B bypass beats port A beats the array.
  always_comb begin
    rd    = '0;
    rpend = '0;
    for (int i = 0; i < NRD; i++) begin
      if (idle && (ra[i*AW +: AW] != '0)) begin
        if (we_b && (wa_b == ra[i*AW +: AW])) begin
          rd[i*DW +: DW] = wd_b;
        end else if (we_a && (wa_a == ra[i*AW +: AW])) begin
          rd[i*DW +: DW] = wd_a;
        end else begin
          rd[i*DW +: DW] = rf[ra[i*AW +: AW]];
        end
        rpend[i] = pend[ra[i*AW +: AW]] &&
                   !((vwa && (wa_a == ra[i*AW +: AW])) ||
                     (vwb && (wa_b == ra[i*AW +: AW])));
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and randomized checks of regfile_mp against a
// behavioural array/scoreboard model kept in the bench.
module tb_regfile_mp;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NRD  = 3;
  localparam int NREG = 32;

  logic              clk;
  logic              rst_n;
  logic              clr;
  logic              busy;
  logic [NRD*AW-1:0] ra;
  logic [NRD*DW-1:0] rd;
  logic [NRD-1:0]    rpend;
  logic              we_a;
  logic [AW-1:0]     wa_a;
  logic [DW-1:0]     wd_a;
  logic              we_b;
  logic [AW-1:0]     wa_b;
  logic [DW-1:0]     wd_b;
  logic              iss_v;
  logic [AW-1:0]     iss_a;

  // reference model: register contents, pending bits, scrub cycles left
  logic [DW-1:0] mRf [NREG];
  bit   [NREG-1:0] mPend;
  int            scrubLeft;

  int total;
  int bad;

  regfile_mp #(.DW(DW), .AW(AW), .NRD(NRD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .busy  (busy),
    .ra    (ra),
    .rd    (rd),
    .rpend (rpend),
    .we_a  (we_a),
    .wa_a  (wa_a),
    .wd_a  (wd_a),
    .we_b  (we_b),
    .wa_b  (wa_b),
    .wd_b  (wd_b),
    .iss_v (iss_v),
    .iss_a (iss_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [AW-1:0] rndAddr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREG-1));
    return AW'($urandom_range(0, 7));
  endfunction

  function automatic logic modelBusy();
    return (!rst_n) || (scrubLeft > 0);
  endfunction

  function automatic logic [DW-1:0] expRd(input logic [AW-1:0] a);
    if (modelBusy() || a == 0) return '0;
    if (we_b && wa_b == a) return wd_b;
    if (we_a && wa_a == a) return wd_a;
    return mRf[a];
  endfunction

  function automatic logic expPend(input logic [AW-1:0] a);
    if (modelBusy() || a == 0) return 1'b0;
    if ((we_a && wa_a == a) || (we_b && wa_b == a)) return 1'b0;
    return mPend[a];
  endfunction

  task automatic applyStimulus(input logic iwe_a, input logic [AW-1:0] iwa_a,
                               input logic [DW-1:0] iwd_a, input logic iwe_b,
                               input logic [AW-1:0] iwa_b, input logic [DW-1:0] iwd_b,
                               input logic iiss_v, input logic [AW-1:0] iiss_a,
                               input logic iclr);
    we_a  = iwe_a;  wa_a = iwa_a; wd_a = iwd_a;
    we_b  = iwe_b;  wa_b = iwa_b; wd_b = iwd_b;
    iss_v = iiss_v; iss_a = iiss_a;
    clr   = iclr;
  endtask

  task automatic idleIns();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic randIns(input int clrOdds);
    applyStimulus(1'($urandom_range(0, 1)), rndAddr(), $urandom(),
                  1'($urandom_range(0, 1)), rndAddr(), $urandom(),
                  1'($urandom_range(0, 1)), rndAddr(),
                  (clrOdds > 0) ? ($urandom_range(1, clrOdds) == 1) : 1'b0);
  endtask

  task automatic setRead(input int p, input logic [AW-1:0] a);
    ra[p*AW +: AW] = a;
  endtask

  task automatic randReads();
    for (int p = 0; p < NRD; p++) setRead(p, rndAddr());
  endtask

  task automatic checkOutput(input string tag);
    logic [DW-1:0] eRd;
    logic          ePd;
    #1;
    total++;
    assert (busy === modelBusy()) else begin
      bad++;
      $error("[TB] FAIL %s busy observed=%0b expected=%0b", tag, busy, modelBusy());
    end
    for (int p = 0; p < NRD; p++) begin
      eRd = expRd(ra[p*AW +: AW]);
      ePd = expPend(ra[p*AW +: AW]);
      total++;
      assert (rd[p*DW +: DW] === eRd) else begin
        bad++;
        $error("[TB] FAIL %s rd%0d addr=%0d observed=%h expected=%h",
               tag, p, ra[p*AW +: AW], rd[p*DW +: DW], eRd);
      end
      total++;
      assert (rpend[p] === ePd) else begin
        bad++;
        $error("[TB] FAIL %s rpend%0d addr=%0d observed=%b expected=%b",
               tag, p, ra[p*AW +: AW], rpend[p], ePd);
      end
    end
  endtask

  // advance one clock and apply this cycle's effects to the model
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      scrubLeft = NREG;
      mPend     = '0;
    end else if (scrubLeft > 0) begin
      scrubLeft--;
      if (scrubLeft == 0) begin
        for (int r = 0; r < NREG; r++) mRf[r] = '0;
      end
    end else if (clr) begin
      scrubLeft = NREG;
      mPend     = '0;
    end else begin
      if (we_a && wa_a != 0) begin mRf[wa_a] = wd_a; mPend[wa_a] = 1'b0; end
      if (we_b && wa_b != 0) begin mRf[wa_b] = wd_b; mPend[wa_b] = 1'b0; end
      if (iss_v && iss_a != 0) mPend[iss_a] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic stepCheck(input string tag);
    checkOutput(tag);
    tick();
  endtask

  task automatic zeroSweep(input string tag);
    idleIns();
    for (int a = 0; a < NREG; a++) begin
      for (int p = 0; p < NRD; p++) setRead(p, AW'((a + p * 11) % NREG));
      stepCheck(tag);
    end
  endtask

  task automatic scrubWindow(input string tag, input int clrOdds);
    for (int k = 0; k < NREG; k++) begin
      randIns(clrOdds);
      randReads();
      stepCheck(tag);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    scrubLeft = NREG;
    mPend = '0;
    for (int r = 0; r < NREG; r++) mRf[r] = '0;
    rst_n = 1'b0;
    ra    = '0;
    idleIns();

    // reset state
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      randIns(0);
      randReads();
      stepCheck("reset");
    end

    // scrub after reset release, then every register reads zero
    rst_n = 1'b1;
    scrubWindow("scrub0", 4);
    zeroSweep("zero0");

    // write with same-cycle bypass, then from the array
    applyStimulus(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    setRead(0, 5'd3); setRead(1, 5'd0); setRead(2, 5'd4);
    stepCheck("wr3_bypass");
    idleIns();
    stepCheck("wr3_array");
    stepCheck("wr3_hold");

    // writes to register 0 are dropped
    applyStimulus(1'b1, 5'd0, 32'h55555555, 1'b1, 5'd0, 32'h66666666, 1'b1, 5'd0, 1'b0);
    setRead(0, 5'd0);
    stepCheck("wr0");
    idleIns();
    stepCheck("wr0_after");

    // both ports on one register: port B wins
    applyStimulus(1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7, 32'h22222222, 1'b0, '0, 1'b0);
    setRead(0, 5'd3); setRead(1, 5'd7); setRead(2, 5'd7);
    stepCheck("dual7");
    idleIns();
    stepCheck("dual7_after");

    // scoreboard: issue, retire by write, issue+write together
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9, 1'b0);
    setRead(0, 5'd9); setRead(1, 5'd9); setRead(2, 5'd7);
    stepCheck("iss9");
    idleIns();
    stepCheck("iss9_pend");
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 32'h0000CAFE, 1'b0, '0, 1'b0);
    stepCheck("wr9_clear");
    idleIns();
    stepCheck("wr9_after");
    applyStimulus(1'b1, 5'd9, 32'h12345678, 1'b0, '0, '0, 1'b1, 5'd9, 1'b0);
    stepCheck("isswr9");
    idleIns();
    stepCheck("isswr9_pend");

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      randIns(0);
      randReads();
      stepCheck("rand1");
    end

    // load 1..31 with some issues, then request a scrub
    for (int a = 1; a < NREG; a++) begin
      applyStimulus(1'b1, AW'(a), $urandom(), 1'b0, '0, '0,
                    1'($urandom_range(0, 1)), AW'($urandom_range(1, NREG-1)), 1'b0);
      randReads();
      stepCheck("load");
    end
    applyStimulus(1'b1, 5'd5, 32'hA5A5A5A5, 1'b1, 5'd6, 32'h5A5A5A5A, 1'b1, 5'd12, 1'b1);
    setRead(0, 5'd12); setRead(1, 5'd13); setRead(2, 5'd14);
    stepCheck("clr");
    scrubWindow("scrub1", 3);
    zeroSweep("zero1");

    // reset dropped at scrub cycle 10
    for (int k = 0; k < 20; k++) begin
      randIns(0);
      randReads();
      stepCheck("rand2");
    end
    idleIns();
    clr = 1'b1;
    stepCheck("clr2");
    for (int k = 0; k < 10; k++) begin
      randIns(0);
      randReads();
      stepCheck("scrub2");
    end
    rst_n = 1'b0;
    scrubLeft = NREG;
    mPend = '0;
    randReads();
    checkOutput("midreset");
    tick();
    tick();
    rst_n = 1'b1;
    scrubWindow("scrub3", 0);
    zeroSweep("zero3");

    for (int k = 0; k < 200; k++) begin
      randIns(64);
      randReads();
      stepCheck("rand3");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
